bus_source_mux: RTL and testbench

//  Source end of the shared 32-bit datapath bus: takes every register's BusMuxIn word and the

---
 rtl/bus_source_mux.sv | 175 +++++++++++++++++
 tb/tb_bus_source_mux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_source_mux.sv
// ============================================================================
// bus_source_mux
// ----------------------------------------------------------------------------
// Source end of the shared datapath bus. Every register presents its word on
// BusMuxIn_flat, and the control unit raises one drive strobe per cycle on
// src_out. The lowest set strobe selects its word, which is registered onto
// BusMuxOut for all bus consumers to load. More than one strobe in a cycle is
// a bus conflict: the lowest index still wins, a one-cycle conflict pulse is
// raised, a saturating conflict counter advances, and the control FSM parks
// in FAULT until fault_ack.
//
// Ports
//   clock          in   rising-edge clock
//   clear          in   synchronous active-high reset, overrides all inputs
//   src_out        in   [NUM_SRC]            drive strobes, strobe i -> word i
//   BusMuxIn_flat  in   [NUM_SRC*DATA_WIDTH] word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fault_ack      in   leaves FAULT (ignored in any other state)
//   BusMuxOut      out  [DATA_WIDTH]  registered bus word
//   bus_valid      out  BusMuxOut was loaded from a source on the last edge
//   bus_sel        out  [SEL_WIDTH]   index of the source now on the bus
//   conflict       out  more than one strobe was seen on the last edge
//   fault          out  high while the FSM is in FAULT
//   conflict_count out  [CNT_WIDTH]   saturating count of conflict cycles
//   bus_parity     out  XOR reduction of BusMuxOut (only with BUS_PARITY_EN)
//
// Build option
//   BUS_PARITY_EN  when defined, adds the bus_parity output and its register.
//
// SEL_WIDTH must satisfy 2**SEL_WIDTH >= NUM_SRC.
// ============================================================================
module bus_source_mux #(
    parameter int NUM_SRC    = 24,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [NUM_SRC-1:0]            src_out,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] BusMuxIn_flat,
    input  logic                          fault_ack,
    output logic [DATA_WIDTH-1:0]         BusMuxOut,
    output logic                          bus_valid,
    output logic [SEL_WIDTH-1:0]          bus_sel,
    output logic                          conflict,
    output logic                          fault,
    output logic [CNT_WIDTH-1:0]          conflict_count
`ifdef BUS_PARITY_EN
    ,
    output logic                          bus_parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------------
    logic                  any_strobe;
    logic                  multi_strobe;
    logic [SEL_WIDTH-1:0]  win_sel;
    logic [DATA_WIDTH-1:0] win_word;
    logic                  count_sat;

    assign any_strobe   = |src_out;
    // Clearing the lowest set bit leaves something behind only if a second
    // strobe is present.
    assign multi_strobe = |(src_out & (src_out - NUM_SRC'(1)));
    assign count_sat    = &conflict_count;

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_sel  = '0;
        win_word = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_sel  = SEL_WIDTH'(i);
                win_word = BusMuxIn_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bus register: word and select hold when nothing drives the bus.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (clear) begin
            BusMuxOut <= '0;
            bus_sel   <= '0;
            bus_valid <= 1'b0;
        end else begin
            bus_valid <= any_strobe;
            if (any_strobe) begin
                BusMuxOut <= win_word;
                bus_sel   <= win_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Conflict pulse and saturating conflict counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else begin
            conflict <= multi_strobe;
            if (multi_strobe && !count_sat) begin
                conflict_count <= conflict_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef BUS_PARITY_EN
    // Parity tracks the word being loaded, so it holds whenever BusMuxOut does.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_parity <= 1'b0;
        end else if (any_strobe) begin
            bus_parity <= ^win_word;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DRIVE: begin
                if (multi_strobe) begin
                    state_next = ST_FAULT;
                end else if (any_strobe) begin
                    state_next = ST_DRIVE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            // The acknowledge wins even over a fresh conflict on the same edge;
            // that conflict is still counted by the counter above.
            ST_FAULT: begin
                if (fault_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fault = (state == ST_FAULT);
    end

endmodule

// File: tb/tb_bus_source_mux.sv
// ============================================================================
// tb_bus_source_mux
// ----------------------------------------------------------------------------
// Directed steps followed by randomized traffic on bus_source_mux. A
// behavioural model of the bus (lowest strobe wins, hold on idle, sticky
// fault, saturating count) is advanced once per clock edge and compared with
// every DUT output one time unit after the edge.
// ============================================================================
module tb_bus_source_mux;

    localparam int NUM_SRC    = 24;
    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 5;
    localparam int CNT_WIDTH  = 8;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic                          clock = 1'b0;
    logic                          clear;
    logic [NUM_SRC-1:0]            src_out;
    logic [NUM_SRC*DATA_WIDTH-1:0] BusMuxIn_flat;
    logic                          fault_ack;
    logic [DATA_WIDTH-1:0]         BusMuxOut;
    logic                          bus_valid;
    logic [SEL_WIDTH-1:0]          bus_sel;
    logic                          conflict;
    logic                          fault;
    logic [CNT_WIDTH-1:0]          conflict_count;
`ifdef BUS_PARITY_EN
    logic                          bus_parity;
`endif

    bus_source_mux #(
        .NUM_SRC   (NUM_SRC),
        .DATA_WIDTH(DATA_WIDTH),
        .SEL_WIDTH (SEL_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .src_out       (src_out),
        .BusMuxIn_flat (BusMuxIn_flat),
        .fault_ack     (fault_ack),
        .BusMuxOut     (BusMuxOut),
        .bus_valid     (bus_valid),
        .bus_sel       (bus_sel),
        .conflict      (conflict),
        .fault         (fault),
        .conflict_count(conflict_count)
`ifdef BUS_PARITY_EN
        ,
        .bus_parity    (bus_parity)
`endif
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_word   = '0;
    int          m_sel    = 0;
    bit          m_valid  = 1'b0;
    bit          m_confl  = 1'b0;
    bit          m_fault  = 1'b0;
    int          m_count  = 0;
    bit          m_parity = 1'b0;

    function automatic int lowest_set(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs present at this edge.
    task automatic model_edge();
        int n;
        int lo;
        if (clear) begin
            m_word = '0; m_sel = 0; m_valid = 0; m_confl = 0;
            m_fault = 0; m_count = 0; m_parity = 0;
            return;
        end
        n  = $countones(src_out);
        lo = lowest_set(src_out);
        m_valid = (n > 0);
        if (n > 0) begin
            m_word   = BusMuxIn_flat[lo*DATA_WIDTH +: DATA_WIDTH];
            m_sel    = lo;
            m_parity = ^m_word;
        end
        m_confl = (n > 1);
        if (n > 1 && m_count < CNT_MAX) m_count++;
        if (m_fault) begin
            if (fault_ack) m_fault = 0;
        end else if (n > 1) begin
            m_fault = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".BusMuxOut"}, BusMuxOut, m_word);
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'(m_sel));
        check({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_valid));
        check({tag, ".conflict"}, 32'(conflict), 32'(m_confl));
        check({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check({tag, ".count"}, 32'(conflict_count), 32'(m_count));
`ifdef BUS_PARITY_EN
        check({tag, ".parity"}, 32'(bus_parity), 32'(m_parity));
`endif
    endtask

    // One clock: edge, model update, compare away from the edge.
    task automatic cycle(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic randomize_words();
        for (int i = 0; i < NUM_SRC; i++) begin
            BusMuxIn_flat[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
        end
    endtask

    function automatic logic [NUM_SRC-1:0] one_strobe(input int idx);
        return NUM_SRC'(1) << idx;
    endfunction

    function automatic logic [NUM_SRC-1:0] multi_strobes();
        int a;
        int b;
        a = $urandom_range(NUM_SRC - 1);
        b = (a + 1 + $urandom_range(NUM_SRC - 2)) % NUM_SRC;
        return one_strobe(a) | one_strobe(b) | (NUM_SRC'($urandom) & NUM_SRC'($urandom));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Step 1: reset with random inputs for two edges.
        clear     = 1'b1;
        fault_ack = 1'($urandom);
        src_out   = NUM_SRC'($urandom);
        randomize_words();
        cycle("reset0");
        src_out   = NUM_SRC'($urandom);
        fault_ack = 1'($urandom);
        randomize_words();
        cycle("reset1");
        check("reset.word_zero", BusMuxOut, 32'h0);
        check("reset.count_zero", 32'(conflict_count), 32'h0);

        // Step 2: single strobe 5.
        clear     = 1'b0;
        fault_ack = 1'b0;
        randomize_words();
        BusMuxIn_flat[5*DATA_WIDTH +: DATA_WIDTH] = 32'hDEADBEEF;
        src_out = one_strobe(5);
        cycle("drive5");
        check("drive5.literal_word", BusMuxOut, 32'hDEADBEEF);
        check("drive5.literal_sel", 32'(bus_sel), 32'd5);

        // Step 3: idle bus holds word and select.
        src_out = '0;
        for (int k = 0; k < 3; k++) begin
            randomize_words();
            cycle("idle_hold");
        end
        check("idle.literal_word", BusMuxOut, 32'hDEADBEEF);
        check("idle.literal_valid", 32'(bus_valid), 32'd0);

        // Step 4: conflict on 3 and 9, word 3 wins.
        BusMuxIn_flat[3*DATA_WIDTH +: DATA_WIDTH] = 32'h12345678;
        src_out = one_strobe(3) | one_strobe(9);
        cycle("conflict");
        check("conflict.literal_word", BusMuxOut, 32'h12345678);
        check("conflict.literal_count", 32'(conflict_count), 32'd1);
        check("conflict.literal_fault", 32'(fault), 32'd1);
        src_out = one_strobe(7);
        cycle("fault_sticky");
        check("fault_sticky.literal", 32'(fault), 32'd1);
        check("conflict_pulse.literal", 32'(conflict), 32'd0);
        fault_ack = 1'b1;
        src_out   = '0;
        cycle("fault_ack");
        check("fault_ack.literal", 32'(fault), 32'd0);

        // Ack outside FAULT is ignored; then ack beats a concurrent conflict.
        src_out = one_strobe(2);
        cycle("ack_ignored");
        fault_ack = 1'b0;
        src_out   = multi_strobes();
        cycle("refault");
        fault_ack = 1'b1;
        src_out   = multi_strobes();
        cycle("ack_vs_conflict");
        check("ack_vs_conflict.literal_fault", 32'(fault), 32'd0);
        check("ack_vs_conflict.literal_count", 32'(conflict_count), 32'd3);
        fault_ack = 1'b0;

        // Step 5: saturate the counter, then clear mid-run.
        for (int k = 0; k < 300; k++) begin
            src_out = multi_strobes();
            randomize_words();
            cycle("saturate");
        end
        check("saturate.literal", 32'(conflict_count), 32'hFF);
        clear = 1'b1;
        cycle("mid_clear");
        check("mid_clear.literal", 32'(conflict_count), 32'h0);
        clear = 1'b0;

`ifdef BUS_PARITY_EN
        // Step 6: parity of the loaded word.
        BusMuxIn_flat[0 +: DATA_WIDTH] = 32'h00000007;
        src_out = one_strobe(0);
        cycle("parity7");
        check("parity7.literal", 32'(bus_parity), 32'd1);
        BusMuxIn_flat[0 +: DATA_WIDTH] = 32'h00000003;
        cycle("parity3");
        check("parity3.literal", 32'(bus_parity), 32'd0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            int kind;
            kind = $urandom_range(9);
            randomize_words();
            if (kind < 3)      src_out = '0;
            else if (kind < 8) src_out = one_strobe($urandom_range(NUM_SRC - 1));
            else               src_out = multi_strobes();
            fault_ack = ($urandom_range(3) == 0);
            clear     = ($urandom_range(49) == 0);
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
